// File: rtl/dft_ctrl_pkg.sv
// Shared types and constants for the direct-DFT sequencer.
package dft_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    CLEAR   = 3'd2,
    COMPUTE = 3'd3,
    DRAIN   = 3'd4,
    DONE    = 3'd5
  } state_t;

  // Shortest transform length accepted on start.
  localparam int unsigned MIN_LEN = 2;

endpackage

// File: rtl/dft_idx_counter.sv
// Index counter with synchronous clear, saturating increment and a "last" flag.
module dft_idx_counter #(
  parameter int unsigned IDX_W = 12
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             ce,
  input  logic             clr,
  input  logic             inc,
  input  logic [IDX_W-1:0] limit,
  output logic [IDX_W-1:0] idx,
  output logic             last
);

  logic [IDX_W-1:0] idx_q;

  // Clear wins over increment; the count never moves past limit.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      idx_q <= '0;
    end else if (ce) begin
      if (clr) begin
        idx_q <= '0;
      end else if (inc && (idx_q != limit)) begin
        idx_q <= idx_q + IDX_W'(1);
      end
    end
  end

  assign idx  = idx_q;
  assign last = (idx_q == limit);

endmodule

// File: rtl/dft_seq_ctrl.sv
// Sequencer for the direct-DFT datapath: cache load, then k/n double loop with
// per-bin accumulator clear, pipeline drain and result strobe.
module dft_seq_ctrl
  import dft_ctrl_pkg::*;
#(
  parameter int unsigned IDX_W    = 12,
  parameter int unsigned PIPE_LAT = 3
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             ce,
  input  logic             start,
  input  logic [IDX_W-1:0] sample_num,
  input  logic             inverse,
  input  logic             abort,
  output logic             load_to_cache,
  output logic [IDX_W-1:0] cache_addr,
  output logic             acc_clear,
  output logic             acc_en,
  output logic [IDX_W-1:0] n_idx,
  output logic [IDX_W-1:0] k_idx,
  output logic             twiddle_conj,
  output logic             bin_valid,
  output logic [IDX_W-1:0] bin_idx,
  output logic             busy,
  output logic             done,
  output logic             len_err,
  output state_t           state
);

  localparam int unsigned DW = (PIPE_LAT < 2) ? 1 : $clog2(PIPE_LAT + 1);
  localparam logic [DW-1:0] DRAIN_LAST = DW'(PIPE_LAT - 1);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] len_q, len_d;
  logic             inv_q, inv_d;
  logic             load_q, load_d;
  logic             acc_clear_q, acc_clear_d;
  logic             acc_en_q, acc_en_d;
  logic             bin_valid_q, bin_valid_d;
  logic [IDX_W-1:0] bin_idx_q, bin_idx_d;
  logic             done_q, done_d;
  logic             len_err_q, len_err_d;
  logic [DW-1:0]    drain_q, drain_d;

  logic [IDX_W-1:0] last_idx;
  logic             addr_clr, addr_inc, addr_last;
  logic             n_clr, n_inc, n_last;
  logic             k_clr, k_inc, k_last;

  assign last_idx = len_q - IDX_W'(1);

  dft_idx_counter #(.IDX_W(IDX_W)) u_addr_cnt (
    .clk(clk), .nrst(nrst), .ce(ce), .clr(addr_clr), .inc(addr_inc),
    .limit(last_idx), .idx(cache_addr), .last(addr_last)
  );

  dft_idx_counter #(.IDX_W(IDX_W)) u_n_cnt (
    .clk(clk), .nrst(nrst), .ce(ce), .clr(n_clr), .inc(n_inc),
    .limit(last_idx), .idx(n_idx), .last(n_last)
  );

  dft_idx_counter #(.IDX_W(IDX_W)) u_k_cnt (
    .clk(clk), .nrst(nrst), .ce(ce), .clr(k_clr), .inc(k_inc),
    .limit(last_idx), .idx(k_idx), .last(k_last)
  );

  // State and registered outputs; everything holds while ce is low.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q     <= IDLE;
      len_q       <= '0;
      inv_q       <= 1'b0;
      load_q      <= 1'b0;
      acc_clear_q <= 1'b0;
      acc_en_q    <= 1'b0;
      bin_valid_q <= 1'b0;
      bin_idx_q   <= '0;
      done_q      <= 1'b0;
      len_err_q   <= 1'b0;
      drain_q     <= '0;
    end else if (ce) begin
      state_q     <= state_d;
      len_q       <= len_d;
      inv_q       <= inv_d;
      load_q      <= load_d;
      acc_clear_q <= acc_clear_d;
      acc_en_q    <= acc_en_d;
      bin_valid_q <= bin_valid_d;
      bin_idx_q   <= bin_idx_d;
      done_q      <= done_d;
      len_err_q   <= len_err_d;
      drain_q     <= drain_d;
    end
  end

  // Next state: outputs are computed for the state being entered so that
  // each strobe lines up with its state once registered.
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    inv_d       = inv_q;
    load_d      = 1'b0;
    acc_clear_d = 1'b0;
    acc_en_d    = 1'b0;
    bin_valid_d = 1'b0;
    bin_idx_d   = bin_idx_q;
    done_d      = 1'b0;
    len_err_d   = 1'b0;
    drain_d     = '0;
    addr_clr    = 1'b0;
    addr_inc    = 1'b0;
    n_clr       = 1'b0;
    n_inc       = 1'b0;
    k_clr       = 1'b0;
    k_inc       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (sample_num >= IDX_W'(MIN_LEN)) begin
            len_d    = sample_num;
            inv_d    = inverse;
            load_d   = 1'b1;
            addr_clr = 1'b1;
            state_d  = LOAD;
          end else begin
            len_err_d = 1'b1;
          end
        end
      end
      LOAD: begin
        if (addr_last) begin
          addr_clr    = 1'b1;
          k_clr       = 1'b1;
          n_clr       = 1'b1;
          acc_clear_d = 1'b1;
          state_d     = CLEAR;
        end else begin
          load_d   = 1'b1;
          addr_inc = 1'b1;
        end
      end
      CLEAR: begin
        n_clr    = 1'b1;
        acc_en_d = 1'b1;
        state_d  = COMPUTE;
      end
      COMPUTE: begin
        if (n_last) begin
          n_clr   = 1'b1;
          state_d = DRAIN;
        end else begin
          acc_en_d = 1'b1;
          n_inc    = 1'b1;
        end
      end
      DRAIN: begin
        if (drain_q == DRAIN_LAST) begin
          bin_valid_d = 1'b1;
          bin_idx_d   = k_idx;
          if (k_last) begin
            done_d  = 1'b1;
            state_d = DONE;
          end else begin
            k_inc       = 1'b1;
            acc_clear_d = 1'b1;
            state_d     = CLEAR;
          end
        end else begin
          drain_d = drain_q + DW'(1);
        end
      end
      DONE: begin
        k_clr   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Abort overrides everything computed above.
    if (abort && (state_q != IDLE)) begin
      state_d     = IDLE;
      load_d      = 1'b0;
      acc_clear_d = 1'b0;
      acc_en_d    = 1'b0;
      bin_valid_d = 1'b0;
      done_d      = 1'b0;
      drain_d     = '0;
      addr_clr    = 1'b1;
      addr_inc    = 1'b0;
      n_clr       = 1'b1;
      n_inc       = 1'b0;
      k_clr       = 1'b1;
      k_inc       = 1'b0;
    end
  end

  assign load_to_cache = load_q;
  assign acc_clear     = acc_clear_q;
  assign acc_en        = acc_en_q;
  assign twiddle_conj  = inv_q;
  assign bin_valid     = bin_valid_q;
  assign bin_idx       = bin_idx_q;
  assign done          = done_q;
  assign len_err       = len_err_q;
  assign busy          = (state_q != IDLE);
  assign state         = state_q;

endmodule

// File: tb/tb_dft_seq_ctrl.sv
// Scoreboard bench for dft_seq_ctrl: the driver predicts the complete event
// stream of each transform (with its ce-cycle timestamp) from the closed-form
// schedule; a monitor pops and compares as the DUT shows activity.
module tb_dft_seq_ctrl;
  import dft_ctrl_pkg::*;

  localparam int unsigned TB_W = 3;
  localparam int unsigned P    = 3;

  localparam int EV_LOAD   = 0;
  localparam int EV_BIN    = 1;
  localparam int EV_DONE   = 2;
  localparam int EV_CLR    = 3;
  localparam int EV_ACC    = 4;
  localparam int EV_LENERR = 5;

  typedef struct {
    int          kind;
    int unsigned a;
    int unsigned b;
    longint      cyc;
    bit          inv;
  } ev_t;

  logic            clk, nrst, ce, start, inverse, abort;
  logic [TB_W-1:0] sample_num;
  logic            load_to_cache, acc_clear, acc_en, twiddle_conj;
  logic            bin_valid, busy, done, len_err;
  logic [TB_W-1:0] cache_addr, n_idx, k_idx, bin_idx;
  state_t          state;

  dft_seq_ctrl #(.IDX_W(TB_W), .PIPE_LAT(P)) dut (
    .clk(clk), .nrst(nrst), .ce(ce), .start(start), .sample_num(sample_num),
    .inverse(inverse), .abort(abort), .load_to_cache(load_to_cache),
    .cache_addr(cache_addr), .acc_clear(acc_clear), .acc_en(acc_en),
    .n_idx(n_idx), .k_idx(k_idx), .twiddle_conj(twiddle_conj),
    .bin_valid(bin_valid), .bin_idx(bin_idx), .busy(busy), .done(done),
    .len_err(len_err), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int     checks = 0;
  int     errors = 0;
  int     acc_seen = 0;
  int     ce_mode = 0;
  longint ce_cyc = 0;
  longint busy_lo = 0;
  longint busy_hi = -1;
  ev_t    exp_q[$];

  task automatic chk(input string name, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (ce-cycle %0d)", name, got, exp, ce_cyc);
    end
  endtask

  // Monitor: one pass per effective (ce=1, out of reset) clock edge.
  initial begin
    ev_t obs[$];
    ev_t ex[$];
    logic ce_e, rst_e;
    bit exp_busy;
    forever begin
      @(posedge clk);
      ce_e  = ce;
      rst_e = nrst;
      #1;
      if (rst_e && nrst && ce_e) begin
        ce_cyc++;
        obs.delete();
        ex.delete();
        if (load_to_cache) obs.push_back('{EV_LOAD, cache_addr, 0, ce_cyc, twiddle_conj});
        if (bin_valid)     obs.push_back('{EV_BIN, bin_idx, 0, ce_cyc, twiddle_conj});
        if (done)          obs.push_back('{EV_DONE, 0, 0, ce_cyc, twiddle_conj});
        if (acc_clear)     obs.push_back('{EV_CLR, k_idx, 0, ce_cyc, twiddle_conj});
        if (acc_en)        obs.push_back('{EV_ACC, k_idx, n_idx, ce_cyc, twiddle_conj});
        if (len_err)       obs.push_back('{EV_LENERR, 0, 0, ce_cyc, twiddle_conj});
        if (acc_en) acc_seen++;
        while (exp_q.size() > 0 && exp_q[0].cyc <= ce_cyc) ex.push_back(exp_q.pop_front());
        chk("event_count", obs.size(), ex.size());
        for (int i = 0; i < obs.size() && i < ex.size(); i++) begin
          chk("event_kind", obs[i].kind, ex[i].kind);
          chk("event_a", obs[i].a, ex[i].a);
          chk("event_b", obs[i].b, ex[i].b);
          if (ex[i].kind != EV_LENERR) chk("twiddle_conj", obs[i].inv, ex[i].inv);
        end
        exp_busy = (ce_cyc >= busy_lo) && (ce_cyc <= busy_hi);
        chk("busy", busy, exp_busy);
        if (!exp_busy) chk("state_idle", state, IDLE);
      end
    end
  end

  task automatic step();
    @(negedge clk);
    case (ce_mode)
      0:       ce = 1'b1;
      1:       ce = ~ce;
      default: ce = 1'($urandom_range(0, 1));
    endcase
  endtask

  // Issue a start and predict the transform's whole event schedule.
  task automatic issue(input int unsigned n, input bit inv, output longint base);
    int guard = 0;
    longint ck, blk;
    while (ce !== 1'b1 && guard < 100) begin step(); guard++; end
    sample_num = TB_W'(n);
    inverse    = inv;
    start      = 1'b1;
    base       = ce_cyc + 1;
    if (n >= 2) begin
      blk = longint'(n) + 1 + P;
      for (int a = 0; a < int'(n); a++) exp_q.push_back('{EV_LOAD, a, 0, base + a, inv});
      for (int k = 0; k < int'(n); k++) begin
        ck = base + n + k * blk;
        exp_q.push_back('{EV_CLR, k, 0, ck, inv});
        for (int m = 0; m < int'(n); m++) exp_q.push_back('{EV_ACC, k, m, ck + 1 + m, inv});
        exp_q.push_back('{EV_BIN, k, 0, ck + blk, inv});
      end
      exp_q.push_back('{EV_DONE, 0, 0, base + n + n * blk, inv});
      busy_lo = base;
      busy_hi = base + n + n * blk;
    end else begin
      exp_q.push_back('{EV_LENERR, 0, 0, base, inv});
    end
    step();
    start      = 1'b0;
    inverse    = ~inv;
    sample_num = TB_W'($urandom);
  endtask

  task automatic wait_cyc(input longint target);
    int guard = 0;
    while (ce_cyc < target && guard < 10000) begin step(); guard++; end
    if (ce_cyc < target) begin
      errors++;
      $display("FAIL wait_cyc: reached %0d required %0d", ce_cyc, target);
    end
  endtask

  task automatic wait_idle();
    int guard = 0;
    while ((exp_q.size() != 0 || ce_cyc <= busy_hi) && guard < 20000) begin step(); guard++; end
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL wait_idle: pending events %0d required 0", exp_q.size());
    end
    step();
    step();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_state"}, state, IDLE);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_load"}, load_to_cache, 0);
    chk({tag, "_addr"}, cache_addr, 0);
    chk({tag, "_acc_clear"}, acc_clear, 0);
    chk({tag, "_acc_en"}, acc_en, 0);
    chk({tag, "_n_idx"}, n_idx, 0);
    chk({tag, "_k_idx"}, k_idx, 0);
    chk({tag, "_twiddle_conj"}, twiddle_conj, 0);
    chk({tag, "_bin_valid"}, bin_valid, 0);
    chk({tag, "_bin_idx"}, bin_idx, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_len_err"}, len_err, 0);
  endtask

  initial begin
    longint base;
    nrst = 1'b0; ce = 1'b1; start = 1'b0; inverse = 1'b0; abort = 1'b0;
    sample_num = '0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    nrst = 1'b1;
    step();

    // Basic N=4 transform and accumulate-enable count.
    acc_seen = 0;
    issue(4, 0, base);
    wait_idle();
    chk("acc_en_total_n4", acc_seen, 16);

    // Illegal lengths.
    issue(1, 0, base);
    wait_idle();
    issue(0, 1, base);
    wait_idle();

    // ce toggling every cycle, inverse toggled after latch.
    ce_mode = 1;
    issue(3, 1, base);
    wait_idle();
    ce_mode = 0;
    step();

    // Abort in COMPUTE at k=1, n=2, then restart.
    issue(4, 0, base);
    wait_cyc(base + 4 + (4 + 1 + P) + 3);
    chk("pre_abort_k", k_idx, 1);
    chk("pre_abort_n", n_idx, 2);
    abort = 1'b1;
    while (exp_q.size() > 0 && exp_q[$].cyc >= ce_cyc + 1) void'(exp_q.pop_back());
    busy_hi = ce_cyc;
    step();
    abort = 1'b0;
    chk("abort_state", state, IDLE);
    chk("abort_k", k_idx, 0);
    chk("abort_n", n_idx, 0);
    chk("abort_acc_en", acc_en, 0);
    wait_idle();
    issue(3, 0, base);
    wait_idle();

    // Reset asserted during DRAIN of bin 0.
    issue(4, 1, base);
    wait_cyc(base + 4 + 4 + 1);
    chk("pre_reset_state", state, DRAIN);
    nrst = 1'b0;
    exp_q.delete();
    busy_hi = -1;
    #1;
    chk_all_zero("mid_reset");
    repeat (2) @(negedge clk);
    nrst = 1'b1;
    step();

    // Longest legal length.
    issue(7, 1, base);
    wait_idle();

    // Randomized transforms with random clock-enable patterns.
    for (int t = 0; t < 8; t++) begin
      ce_mode = int'($urandom_range(0, 2));
      issue($urandom_range(0, 7), 1'($urandom_range(0, 1)), base);
      wait_idle();
    end
    ce_mode = 0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
